// File: rtl/alu_writeback_stage.sv
// ALU writeback buffer: one-entry skid between ALU and register file that
// evaluates the condition code against the architectural NZCV flags.
module alu_writeback_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_result,
  input  logic         in_n,
  input  logic         in_z,
  input  logic         in_co,
  input  logic         in_ovf,
  input  logic [3:0]   in_cond,
  input  logic         in_set_flags,
  input  logic [3:0]   in_rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_rd,
  output logic         out_we,
  output logic [3:0]   flags,
  output logic [7:0]   skip_count
);

  logic f_n, f_z, f_c, f_v;
  logic pass;
  logic accept;

  assign f_n = flags[3];
  assign f_z = flags[2];
  assign f_c = flags[1];
  assign f_v = flags[0];

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Condition is judged on the flags as they stand before this instruction.
  always_comb begin
    pass = 1'b0;
    case (in_cond)
      4'd0:  pass = f_z;
      4'd1:  pass = ~f_z;
      4'd2:  pass = f_c;
      4'd3:  pass = ~f_c;
      4'd4:  pass = f_n;
      4'd5:  pass = ~f_n;
      4'd6:  pass = f_v;
      4'd7:  pass = ~f_v;
      4'd8:  pass = f_c & ~f_z;
      4'd9:  pass = ~f_c | f_z;
      4'd10: pass = (f_n == f_v);
      4'd11: pass = (f_n != f_v);
      4'd12: pass = ~f_z & (f_n == f_v);
      4'd13: pass = f_z | (f_n != f_v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
      flags      <= '0;
      skip_count <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= in_result;
      out_rd     <= in_rd;
      out_we     <= pass;
      if (pass && in_set_flags)
        flags <= {in_n, in_z, in_co, in_ovf};
      // Failed entries still occupy the buffer to keep writeback order.
      if (!pass && skip_count != 8'hFF)
        skip_count <= skip_count + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Randomized self-checking bench for alu_writeback_stage against a
// transaction-level model of the buffer, flags and skip counter.
module tb_alu_writeback_stage;

  localparam int unsigned W = 8;

  localparam logic [3:0] C_NE = 4'd1;
  localparam logic [3:0] C_MI = 4'd4;
  localparam logic [3:0] C_PL = 4'd5;
  localparam logic [3:0] C_AL = 4'd14;
  localparam logic [3:0] C_NV = 4'd15;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_result;
  logic         in_n, in_z, in_co, in_ovf;
  logic [3:0]   in_cond;
  logic         in_set_flags;
  logic [3:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_rd;
  logic         out_we;
  logic [3:0]   flags;
  logic [7:0]   skip_count;

  alu_writeback_stage #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_n(in_n), .in_z(in_z), .in_co(in_co), .in_ovf(in_ovf),
    .in_cond(in_cond), .in_set_flags(in_set_flags), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .flags(flags), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: the single buffered entry, NZCV, and skip tally.
  bit           m_valid;
  logic [W-1:0] m_res;
  logic [3:0]   m_rd;
  bit           m_we;
  bit           m_n, m_z, m_c, m_v;
  int unsigned  m_skip;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c);
    case (c)
      4'd0:  return m_z;
      4'd1:  return !m_z;
      4'd2:  return m_c;
      4'd3:  return !m_c;
      4'd4:  return m_n;
      4'd5:  return !m_n;
      4'd6:  return m_v;
      4'd7:  return !m_v;
      4'd8:  return m_c && !m_z;
      4'd9:  return !m_c || m_z;
      4'd10: return m_n == m_v;
      4'd11: return m_n != m_v;
      4'd12: return !m_z && (m_n == m_v);
      4'd13: return m_z || (m_n != m_v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = '0; m_rd = '0; m_we = 0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_skip = 0;
  endtask

  task automatic check_state(input bit ordy);
    check_eq("in_ready",   in_ready,   !m_valid || ordy);
    check_eq("out_valid",  out_valid,  m_valid);
    check_eq("out_result", out_result, m_res);
    check_eq("out_rd",     out_rd,     m_rd);
    check_eq("out_we",     out_we,     m_we);
    check_eq("flags",      flags,      {m_n, m_z, m_c, m_v});
    check_eq("skip_count", skip_count, m_skip);
  endtask

  task automatic step(input bit iv, input logic [W-1:0] res, input logic [3:0] nzcv,
                      input logic [3:0] cond, input bit sf, input logic [3:0] rd, input bit ordy);
    bit acc, p;
    in_valid = iv; in_result = res;
    {in_n, in_z, in_co, in_ovf} = nzcv;
    in_cond = cond; in_set_flags = sf; in_rd = rd; out_ready = ordy;
    @(negedge clk);
    check_state(ordy);
    acc = iv && (!m_valid || ordy);
    p   = cond_holds(cond);
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1; m_res = res; m_rd = rd; m_we = p;
      if (p && sf) {m_n, m_z, m_c, m_v} = nzcv;
      if (!p && m_skip < 255) m_skip++;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic idle_look();
    step(0, '0, '0, C_NV, 0, '0, 0);
  endtask

  task automatic rand_step();
    step(($urandom % 4) != 0, W'($urandom), 4'($urandom), 4'($urandom),
         1'($urandom), 4'($urandom), ($urandom % 10) < 7);
  endtask

  // Presents a live transaction during reset; it must be dropped.
  task automatic do_reset();
    reset_n = 0;
    in_valid = 1; in_result = 8'hEE; {in_n, in_z, in_co, in_ovf} = 4'hF;
    in_cond = C_AL; in_set_flags = 1; in_rd = 4'hF; out_ready = 0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    check_eq("rst_out_valid",  out_valid,  0);
    check_eq("rst_flags",      flags,      0);
    check_eq("rst_skip_count", skip_count, 0);
    check_eq("rst_in_ready",   in_ready,   1);
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();
    idle_look();

    // Flag update with AL.
    step(1, 8'h00, 4'b0110, C_AL, 1, 4'd3, 1);
    idle_look();
    check_eq("s35_flags", flags, 4'b0110);
    check_eq("s35_we", out_we, 1);
    check_eq("s35_rd", out_rd, 3);

    // Condition fail leaves flags and bumps skip_count.
    step(1, 8'h5A, 4'b1001, C_NE, 1, 4'd5, 1);
    idle_look();
    check_eq("s36_we", out_we, 0);
    check_eq("s36_flags", flags, 4'b0110);
    check_eq("s36_skip", skip_count, 1);

    // Back-to-back visibility.
    step(1, 8'h11, 4'b1000, C_AL, 1, 4'd1, 1);
    step(1, 8'h22, 4'b0000, C_MI, 0, 4'd2, 1);
    check_eq("s37_mi_we", out_we, 1);
    step(1, 8'h33, 4'b1000, C_AL, 1, 4'd1, 1);
    step(1, 8'h44, 4'b0000, C_PL, 0, 4'd2, 1);
    check_eq("s37_pl_we", out_we, 0);

    // Stall then same-cycle swap.
    step(1, 8'hA1, 4'b0000, C_AL, 0, 4'd7, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, W'($urandom), 4'($urandom), C_AL, 1, 4'd8, 0);
      check_eq("s38_in_ready", in_ready, 0);
      check_eq("s38_hold", out_result, 8'hA1);
    end
    step(1, 8'hB2, 4'b0000, C_AL, 0, 4'd9, 1);
    check_eq("s38_swap_valid", out_valid, 1);
    check_eq("s38_swap_result", out_result, 8'hB2);

    for (int i = 0; i < 600; i++) rand_step();

    // Saturation.
    do_reset();
    step(1, 8'h01, 4'b1011, C_AL, 1, 4'd0, 1);
    for (int i = 0; i < 300; i++)
      step(1, W'($urandom), 4'($urandom), C_NV, 1, 4'($urandom), 1);
    idle_look();
    check_eq("s39_skip", skip_count, 255);
    check_eq("s39_flags", flags, 4'b1011);

    for (int i = 0; i < 600; i++) rand_step();

    // Reset mid-stall.
    step(1, 8'hC3, 4'b1111, C_AL, 1, 4'd4, 1);
    step(1, 8'hD4, 4'b0000, C_AL, 1, 4'd6, 0);
    step(1, 8'hD4, 4'b0000, C_AL, 1, 4'd6, 0);
    do_reset();
    idle_look();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 SHALL have parameter W, default 8, meaning the data width of the result path, equal to the ALU width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning an upstream ALU transaction is present.
REQ-005 SHALL have port in_ready, output, 1, meaning the stage accepts this cycle.
REQ-006 SHALL have port in_result, input, W, meaning the ALU result.
REQ-007 SHALL have ports in_n, in_z, in_co and in_ovf, each input, 1, meaning the ALU negative, zero, carry and overflow flags.
REQ-008 SHALL have port in_cond, input, 4, meaning the condition code of the instruction.
REQ-009 SHALL have port in_set_flags, input, 1, meaning the instruction updates the flags.
REQ-010 SHALL have port in_rd, input, 4, meaning the destination register index.
REQ-011 SHALL have port out_valid, output, 1, meaning the buffered entry is valid.
REQ-012 SHALL have port out_ready, input, 1, meaning the register file consumes this cycle.
REQ-013 SHALL have port out_result, output, W, meaning the buffered result.
REQ-014 SHALL have port out_rd, output, 4, meaning the buffered destination.
REQ-015 SHALL have port out_we, output, 1, meaning the register write enable, set when the condition passed.
REQ-016 SHALL have port flags, output, 4, meaning the architectural NZCV register: [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-017 SHALL have port skip_count, output, 8, meaning the number of condition-failed transactions.

Function
REQ-018 SHALL drive in_ready = ~out_valid | out_ready; this is purely combinational with no internal wait states.
REQ-019 SHALL accept a transaction when in_valid & in_ready is high at a rising clk edge.
REQ-020 SHALL evaluate the condition pass against the current flags register, i.e. the value before this transaction's update.
REQ-021 SHALL decode in_cond as follows:
- 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C
- 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
- 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V
- 12 GT ~Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0
REQ-022 On accept, SHALL load out_result, out_rd and out_we=pass into the buffer, and set out_valid=1 at the next cycle.
REQ-023 On accept with pass & in_set_flags, SHALL load flags <= {in_n, in_z, in_co, in_ovf}; otherwise flags SHALL hold.
REQ-024 On accept with pass=0, SHALL still buffer the entry with out_we=0 so ordering is preserved, and SHALL increment skip_count.
REQ-025 SHALL saturate skip_count at 255 with no wrap-around.
REQ-026 For back-to-back accepts, the second transaction's condition SHALL see the flags written by the first (one-cycle visibility).
REQ-027 For a simultaneous consume (out_valid & out_ready) and accept in one cycle, SHALL replace the buffer with the new entry and keep out_valid=1, with no bubble.
REQ-028 For a consume without accept, SHALL clear out_valid next cycle; out_result, out_rd and out_we SHALL hold their stale values.
REQ-029 While out_valid=1 and out_ready=0 (stall), SHALL keep out_result, out_rd, out_we and out_valid stable and deassert in_ready.
REQ-030 SHALL never modify flags or skip_count when no transaction is accepted.
REQ-031 SHALL perform no arithmetic on the result; in_result passes through the buffer bit-exact, width W.

Reset
REQ-032 With reset_n=0 at a rising edge, SHALL set out_valid=0, out_result=0, out_rd=0, out_we=0, flags=4'b0000 and skip_count=0.
REQ-033 During reset, in_ready SHALL read 1 the cycle after reset is sampled; an input presented in a reset cycle SHALL be discarded.
REQ-034 A reset applied while an entry is buffered or stalled SHALL drop that entry, with out_valid=0 the next cycle.

Verification
REQ-035 SHALL cover this flag-update scenario: AL, set_flags=1, in_n=0, in_z=1, in_co=1, in_ovf=0, result 8'h00, rd=3 -> out_valid=1, out_we=1, out_rd=3, flags=4'b0110.
REQ-036 SHALL cover this condition-fail scenario: with flags=0110, in_cond=NE, set_flags=1, result 8'h5A -> out_we=0, flags unchanged 0110, skip_count increments by 1.
REQ-037 SHALL cover this back-to-back scenario: first AL sets flags to 1000 (N), second is MI -> second out_we=1; if the second is PL -> out_we=0.
REQ-038 SHALL cover this stall scenario: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_result stable; then out_ready=1 -> same-cycle swap with no bubble.
REQ-039 SHALL cover this saturation scenario: 300 NV transactions -> skip_count=255 and flags unchanged.
REQ-040 SHALL cover this reset scenario: reset_n=0 mid-stall with out_valid=1 -> next cycle out_valid=0, flags=0000, skip_count=0, in_ready=1.
